// File: rtl/linear_layer_fifo_pkg.sv
// -----------------------------------------------------------------------------
// linear_layer_fifo_pkg
// Shared definitions for the linear-layer SRL FIFO:
//   - out_state_e   : output-register FSM encoding (OUT_EMPTY / OUT_VALID)
//   - clog2()       : elaboration-time ceil(log2) for address sizing
//   - DEFAULT_*     : default geometry and almost-full threshold
// No ports (package).
// -----------------------------------------------------------------------------
package linear_layer_fifo_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_NUM_CH       = 2;
  localparam int DEFAULT_DEPTH        = 16;
  localparam int DEFAULT_AFULL_THRESH = 14;

  // Smallest r with 2**r >= value (value >= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/linear_layer_srl_store.sv
// -----------------------------------------------------------------------------
// linear_layer_srl_store
// Shift-register storage, WIDTH bits x DEPTH entries, with an asynchronous
// (combinational) read port. Contents are not reset.
// Ports:
//   clk   in  rising-edge clock
//   we    in  shift enable: entry 0 takes din, entry i takes entry i-1
//   addr  in  read address (0 = newest)
//   din   in  WIDTH-bit write data
//   dout  out WIDTH-bit data at addr
// -----------------------------------------------------------------------------
module linear_layer_srl_store #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign dout = r_mem[addr];

endmodule

// File: rtl/linear_layer_srl_fifo_mc.sv
// -----------------------------------------------------------------------------
// linear_layer_srl_fifo_mc
// Multi-channel SRL FIFO: NUM_CH lanes of DATA_WIDTH bits share one handshake.
// Optional output register (OUT_REG=1) adds one entry of capacity and breaks
// the combinational SRL read path.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   if_full_n         out  space available in the SRL
//   if_write_ce/write in   write clock-enable / request
//   if_din            in   NUM_CH*DATA_WIDTH, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   if_almost_full    out  if_count >= AFULL_THRESH
//   if_empty_n        out  if_dout holds valid data
//   if_read_ce/read   in   read clock-enable / request
//   if_dout           out  oldest entry
//   if_count          out  total occupancy (SRL + output register)
// -----------------------------------------------------------------------------
module linear_layer_srl_fifo_mc
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int NUM_CH       = DEFAULT_NUM_CH,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH   = clog2(DEPTH),
  parameter int AFULL_THRESH = DEFAULT_AFULL_THRESH,
  parameter int OUT_REG      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         if_full_n,
  input  logic                         if_write_ce,
  input  logic                         if_write,
  input  logic [NUM_CH*DATA_WIDTH-1:0] if_din,
  output logic                         if_almost_full,
  output logic                         if_empty_n,
  input  logic                         if_read_ce,
  input  logic                         if_read,
  output logic [NUM_CH*DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]          if_count
);

  localparam int W = NUM_CH * DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AFULL = (ADDR_WIDTH+1)'(AFULL_THRESH);

  logic [ADDR_WIDTH:0]   r_cnt;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [W-1:0]          w_srl_dout;
  logic                  w_full_n;
  logic                  w_empty_n;
  logic                  w_push;
  logic                  w_pop_ext;
  logic                  w_srl_pop;
  logic                  w_out_valid;
  logic [W-1:0]          w_dout;

  assign w_full_n  = (r_cnt != C_DEPTH);
  assign w_push    = if_write & if_write_ce & w_full_n;
  assign w_pop_ext = if_read & if_read_ce & w_empty_n;

  // cnt-1 saturated at 0. The low ADDR_WIDTH bits suffice because
  // cnt-1 < DEPTH <= 2**ADDR_WIDTH, so the modulo subtraction is exact.
  assign w_addr = (r_cnt == '0) ? '0 : (r_cnt[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      case ({w_push, w_srl_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  linear_layer_srl_store #(
    .WIDTH      (W),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_store (
    .clk  (clk),
    .we   (w_push),
    .addr (w_addr),
    .din  (if_din),
    .dout (w_srl_dout)
  );

  generate
    if (OUT_REG != 0) begin : g_out_reg
      out_state_e r_state;
      out_state_e w_state_next;
      logic       w_load;
      logic [W-1:0] r_dout_reg;
      logic       w_srl_nonempty;

      assign w_srl_nonempty = (r_cnt != '0);

      always_ff @(posedge clk) begin
        if (reset) r_state <= OUT_EMPTY;
        else       r_state <= w_state_next;
      end

      always_comb begin
        w_state_next = r_state;
        case (r_state)
          OUT_EMPTY: if (w_srl_nonempty) w_state_next = OUT_VALID;
          OUT_VALID: if (w_pop_ext && !w_srl_nonempty) w_state_next = OUT_EMPTY;
          default:   w_state_next = OUT_EMPTY;
        endcase
      end

      // Loading the output register is the SRL's pop: either filling an
      // empty stage or refilling right behind a consumer pop.
      always_comb begin
        w_load = 1'b0;
        case (r_state)
          OUT_EMPTY: w_load = w_srl_nonempty;
          OUT_VALID: w_load = w_pop_ext && w_srl_nonempty;
          default:   w_load = 1'b0;
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset)       r_dout_reg <= '0;
        else if (w_load) r_dout_reg <= w_srl_dout;
      end

      assign w_srl_pop   = w_load;
      assign w_empty_n   = (r_state == OUT_VALID);
      assign w_out_valid = (r_state == OUT_VALID);
      assign w_dout      = r_dout_reg;
    end else begin : g_no_out_reg
      assign w_srl_pop   = w_pop_ext;
      assign w_empty_n   = (r_cnt != '0);
      assign w_out_valid = 1'b0;
      assign w_dout      = w_srl_dout;
    end
  endgenerate

  assign if_full_n      = w_full_n;
  assign if_empty_n     = w_empty_n;
  assign if_dout        = w_dout;
  assign if_count       = r_cnt + (ADDR_WIDTH+1)'(w_out_valid);
  assign if_almost_full = (if_count >= C_AFULL);

endmodule

// File: tb/tb_linear_layer_srl_fifo_mc.sv
// Two instances (OUT_REG=0 and OUT_REG=1) receive identical stimulus; each is
// compared against its own queue-based reference model after every clock.
module tb_linear_layer_srl_fifo_mc;

  localparam int DW    = 8;
  localparam int NC    = 2;
  localparam int W     = DW * NC;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AF    = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         wr = 1'b0, wce = 1'b0, rd = 1'b0, rce = 1'b0;
  logic [W-1:0] din = '0;

  logic         full_n0, af0, empty_n0;
  logic [W-1:0] dout0;
  logic [AW:0]  count0;
  logic         full_n1, af1, empty_n1;
  logic [W-1:0] dout1;
  logic [AW:0]  count1;

  linear_layer_srl_fifo_mc #(
    .DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .AFULL_THRESH(AF), .OUT_REG(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .if_full_n(full_n0), .if_write_ce(wce),
    .if_write(wr), .if_din(din), .if_almost_full(af0), .if_empty_n(empty_n0),
    .if_read_ce(rce), .if_read(rd), .if_dout(dout0), .if_count(count0)
  );

  linear_layer_srl_fifo_mc #(
    .DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .AFULL_THRESH(AF), .OUT_REG(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .if_full_n(full_n1), .if_write_ce(wce),
    .if_write(wr), .if_din(din), .if_almost_full(af1), .if_empty_n(empty_n1),
    .if_read_ce(rce), .if_read(rd), .if_dout(dout1), .if_count(count1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference models: dut0 is a plain queue of DEPTH entries; dut1 is a
  // queue of DEPTH entries feeding a one-entry holding slot.
  logic [W-1:0] q0[$];
  logic [W-1:0] s1[$];
  bit           ov1 = 1'b0;
  logic [W-1:0] od1 = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int c0, c1;
    c0 = q0.size();
    c1 = s1.size() + int'(ov1);
    check_val("d0.full_n",  32'(full_n0),  32'(c0 != DEPTH));
    check_val("d0.empty_n", 32'(empty_n0), 32'(c0 != 0));
    check_val("d0.count",   32'(count0),   32'(c0));
    check_val("d0.afull",   32'(af0),      32'(c0 >= AF));
    if (c0 != 0) check_val("d0.dout", 32'(dout0), 32'(q0[0]));
    check_val("d1.full_n",  32'(full_n1),  32'(s1.size() != DEPTH));
    check_val("d1.empty_n", 32'(empty_n1), 32'(ov1));
    check_val("d1.count",   32'(count1),   32'(c1));
    check_val("d1.afull",   32'(af1),      32'(c1 >= AF));
    check_val("d1.dout",    32'(dout1),    32'(od1));
  endtask

  // One clock: drive inputs, advance both models from pre-edge state, check.
  task automatic step(input bit rst, input bit w, input bit we_, input bit r,
                      input bit re_, input logic [W-1:0] d);
    bit p0, pp0, p1, pe1, ld1;
    logic [W-1:0] junk;
    reset = rst; wr = w; wce = we_; rd = r; rce = re_; din = d;
    p0  = w && we_ && (q0.size() != DEPTH);
    pp0 = r && re_ && (q0.size() != 0);
    p1  = w && we_ && (s1.size() != DEPTH);
    pe1 = r && re_ && ov1;
    ld1 = (!ov1 || pe1) && (s1.size() != 0);
    @(posedge clk);
    if (rst) begin
      q0.delete(); s1.delete(); ov1 = 1'b0; od1 = '0;
    end else begin
      if (pp0) junk = q0.pop_front();
      if (p0) q0.push_back(d);
      if (ld1) begin od1 = s1.pop_front(); ov1 = 1'b1; end
      else if (pe1) ov1 = 1'b0;
      if (p1) s1.push_back(d);
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [W-1:0] d;

    // Reset
    step(1, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, '0);
    check_val("rst.count0", 32'(count0), 0);
    check_val("rst.empty_n1", 32'(empty_n1), 0);
    check_val("rst.dout1", 32'(dout1), 0);
    $display("reset done: count0=%0d count1=%0d", count0, count1);

    // Fill: 17 pushes, the 17th is ignored by dut0
    for (int k = 0; k < 17; k++) begin
      d = {8'(8'hA0 + k), 8'(k)};
      step(0, 1, 1, 0, 1, d);
      $display("push %0d din=%04h count0=%0d count1=%0d af0=%0b full_n0=%0b",
               k, d, count0, count1, af0, full_n0);
      if (k == 12) check_val("fill.af_before14", 32'(af0), 0);
      if (k == 13) check_val("fill.af_at14", 32'(af0), 1);
      if (k == 14) check_val("fill.full_n_at15", 32'(full_n0), 1);
      if (k == 15) check_val("fill.full_n_at16", 32'(full_n0), 0);
    end
    check_val("fill.count0", 32'(count0), 16);
    check_val("fill.count1", 32'(count1), 17);

    // Drain: check lanes before each pop
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        check_val("drain.lane0", 32'(dout0[7:0]),  32'(k));
        check_val("drain.lane1", 32'(dout0[15:8]), 32'(8'hA0 + k));
      end
      if (k < 17) begin
        check_val("drain1.lane0", 32'(dout1[7:0]),  32'(k));
        check_val("drain1.lane1", 32'(dout1[15:8]), 32'(8'hA0 + k));
      end
      step(0, 0, 1, 1, 1, '0);
      $display("pop %0d count0=%0d count1=%0d empty_n0=%0b empty_n1=%0b",
               k, count0, count1, empty_n0, empty_n1);
    end
    check_val("drain.empty_n0", 32'(empty_n0), 0);
    check_val("drain.empty_n1", 32'(empty_n1), 0);
    check_val("drain.count1", 32'(count1), 0);

    // Output-register latency: visible 2 cycles after the push edge
    step(0, 1, 1, 0, 1, 16'h55AA);
    check_val("lat.empty_n0_1cyc", 32'(empty_n0), 1);
    check_val("lat.empty_n1_1cyc", 32'(empty_n1), 0);
    step(0, 0, 1, 0, 1, '0);
    check_val("lat.empty_n1_2cyc", 32'(empty_n1), 1);
    check_val("lat.dout1", 32'(dout1), 32'h55AA);
    for (int k = 0; k < 4; k++) step(0, 1, 1, 0, 1, 16'($urandom));

    // Steady state at count 5
    for (int k = 0; k < 100; k++) begin
      d = 16'($urandom);
      step(0, 1, 1, 1, 1, d);
      $display("steady %0d din=%04h dout0=%04h dout1=%04h count0=%0d count1=%0d",
               k, d, dout0, dout1, count0, count1);
      check_val("steady.count0", 32'(count0), 5);
      check_val("steady.count1", 32'(count1), 5);
    end

    // Write clock-enable low freezes the write side
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 0, 0, 1, 16'($urandom));
      $display("wce0 %0d count0=%0d count1=%0d", k, count0, count1);
      check_val("wce0.count0", 32'(count0), 5);
    end
    for (int k = 0; k < 4; k++) step(0, 1, 1, 0, 1, 16'($urandom));
    check_val("pre_rst.count0", 32'(count0), 9);

    // Reset during a push
    step(1, 1, 1, 0, 1, 16'($urandom));
    $display("mid reset: count0=%0d empty_n0=%0b full_n0=%0b", count0, empty_n0, full_n0);
    check_val("midrst.count0", 32'(count0), 0);
    check_val("midrst.empty_n0", 32'(empty_n0), 0);
    check_val("midrst.full_n0", 32'(full_n0), 1);
    check_val("midrst.count1", 32'(count1), 0);

    // Randomised traffic with both clock-enables and occasional reset
    for (int k = 0; k < 400; k++) begin
      bit rs, w, we_, r, re_;
      rs  = ($urandom_range(0, 99) == 0);
      w   = ($urandom_range(0, 3) != 0);
      we_ = ($urandom_range(0, 5) != 0);
      r   = ($urandom_range(0, 3) != 0);
      re_ = ($urandom_range(0, 5) != 0);
      if (k >= 150 && k < 250) r = ($urandom_range(0, 3) == 0); // drive toward full
      d = 16'($urandom);
      step(rs, w, we_, r, re_, d);
      $display("rand %0d rst=%0b w=%0b wce=%0b r=%0b rce=%0b din=%04h count0=%0d count1=%0d",
               k, rs, w, we_, r, re_, d, count0, count1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
